// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings and LSU state type, used by the LSU and the core's decoder.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } lsu_state_e;

endpackage

// File: rtl/rv32i_lsu_align.sv
// Combinational byte-lane logic: store replication/strobes, load extraction/extension,
// and the illegal-funct3 / misalignment check.
module rv32i_lsu_align
  import rv32i_pkg::*;
(
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] lane_wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data,
  output logic        err
);

  logic [31:0] shifted;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    lane_wdata = wdata;
    wstrb      = 4'b0000;
    err        = 1'b0;
    case (funct3)
      F3_B: begin
        lane_wdata = {4{wdata[7:0]}};
        wstrb      = 4'b0001 << offset;
      end
      F3_H: begin
        lane_wdata = {2{wdata[15:0]}};
        wstrb      = 4'b0011 << {offset[1], 1'b0};
        err        = offset[0];
      end
      F3_W: begin
        wstrb = 4'b1111;
        err   = (offset != 2'b00);
      end
      F3_BU:   err = store;
      F3_HU:   err = store | offset[0];
      default: err = 1'b1;
    endcase
    if (!store) wstrb = 4'b0000;
  end

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = shifted;
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/rv32i_lsu.sv
// Load/store unit: accepts one access at a time, runs the data-memory valid/ready
// handshake with a REQ+WAIT timeout, and returns extended load data or an error.
module rv32i_lsu
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  output logic [4:0]  rsp_rd,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  lsu_state_e  state;
  logic [CW-1:0] count;
  logic        lat_store;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_offset;

  logic        a_store;
  logic [2:0]  a_funct3;
  logic [1:0]  a_offset;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic [31:0] load_data;
  logic        acc_err;
  logic        timeout_hit;

  // In IDLE the align logic checks the incoming request; afterwards it extracts for the latched one.
  assign a_store  = (state == ST_IDLE) ? req_store  : lat_store;
  assign a_funct3 = (state == ST_IDLE) ? req_funct3 : lat_funct3;
  assign a_offset = (state == ST_IDLE) ? req_addr[1:0] : lat_offset;

  assign timeout_hit = TO_EN && (count == CNT_LAST);

  rv32i_lsu_align u_align (
    .store      (a_store),
    .funct3     (a_funct3),
    .offset     (a_offset),
    .wdata      (req_wdata),
    .rdata      (mem_rdata),
    .lane_wdata (lane_wdata),
    .wstrb      (lane_wstrb),
    .load_data  (load_data),
    .err        (acc_err)
  );

  // NOTE: all state and registered outputs use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      count      <= '0;
      lat_store  <= 1'b0;
      lat_funct3 <= 3'b000;
      lat_offset <= 2'b00;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rd     <= 5'd0;
      rsp_data   <= 32'h0;
      rsp_err    <= 1'b0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_wstrb  <= 4'b0000;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_store  <= req_store;
            lat_funct3 <= req_funct3;
            lat_offset <= req_addr[1:0];
            rsp_rd     <= req_rd;
            rsp_data   <= 32'h0;
            rsp_err    <= 1'b0;
            count      <= '0;
            req_ready  <= 1'b0;
            mem_addr   <= {req_addr[31:2], 2'b00};
            mem_we     <= req_store;
            mem_wdata  <= req_store ? lane_wdata : 32'h0;
            mem_wstrb  <= lane_wstrb;
            if (acc_err) begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              mem_valid <= 1'b1;
              state     <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (!timeout_hit) count <= count + 1'b1;
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (lat_store) begin
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              state <= ST_WAIT;
            end
          end else if (timeout_hit) begin
            mem_valid <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_WAIT: begin
          if (!timeout_hit) count <= count + 1'b1;
          if (mem_rvalid) begin
            rsp_data  <= load_data;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else if (timeout_hit) begin
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
